// File: rtl/percept_bus_pkg.sv
// Shared definitions for the percept serial bus interface: FSM state
// encoding, opcode constants and the broadcast-address helper.
// Optional feature macro: PERCEPT_BUS_PARITY_EN (even parity on both directions).
package percept_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_OP    = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_EXEC  = 3'd6,
        ST_REPLY = 3'd7
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MAC   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    // True when the low 'width' bits of 'field' are all ones.
    function automatic logic is_broadcast(input logic [63:0] field, input int width);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < width && !field[i]) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/percept_bus_tx.sv
// Reply transmitter: parallel load, then shifts start 0, data LSB first,
// optional even parity, stop 1, each bit held CLKS_PER_BIT clocks.
// done pulses for one cycle after the stop bit period.
// Optional feature macro: PERCEPT_BUS_PARITY_EN.
module percept_bus_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              serial_out,
    output logic              done
);
`ifdef PERCEPT_BUS_PARITY_EN
    localparam int FRAME_W = DATA_W + 3;
`else
    localparam int FRAME_W = DATA_W + 2;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               active_reg;

`ifdef PERCEPT_BUS_PARITY_EN
    assign frame = {1'b1, ^data, data, 1'b0};
`else
    assign frame = {1'b1, data, 1'b0};
`endif

    // Bit-timed shifter; line idles high and returns high at once on reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            active_reg <= 1'b0;
            shift_reg  <= '1;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            serial_out <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                active_reg <= 1'b1;
                shift_reg  <= frame;
                serial_out <= frame[0];
                cnt_reg    <= '0;
                idx_reg    <= '0;
            end else if (active_reg) begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_reg <= '0;
                    if (idx_reg == FRAME_LAST) begin
                        active_reg <= 1'b0;
                        done       <= 1'b1;
                        serial_out <= 1'b1;
                    end else begin
                        idx_reg    <= idx_reg + 1'b1;
                        shift_reg  <= {1'b1, shift_reg[FRAME_W-1:1]};
                        serial_out <= shift_reg[1];
                    end
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/percept_bus_if.sv
// Serial bus front end for a percept core: receives addressed frames
// (start, address MSB-first, opcode MSB-first, payload LSB-first, stop),
// drives the core controls for WRITE / MAC / READ and sends READ replies.
// Optional feature macro: PERCEPT_BUS_PARITY_EN (even parity after payload
// on requests and before stop on replies).
import percept_bus_pkg::*;

module percept_bus_if #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              serial_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              data_out,
    output logic              shift_in,
    output logic              shift_out,
    output logic              mul_and_acc,
    output logic              data_in,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_err
);
`ifdef PERCEPT_BUS_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(ADDR_W + DATA_W + 2);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_W - 1);
    localparam logic [IDX_W-1:0] OP_LAST   = IDX_W'(1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W + PAR_BITS - 1);
    localparam logic [IDX_W-1:0] XFER_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] XFER_END  = IDX_W'(DATA_W);

    logic [1:0]        sync_reg;
    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] payload_reg;
    logic [DATA_W-1:0] rd_buf_reg;
    logic              tx_load_reg;
    logic              tx_done;
    logic              rx;
    logic              bit_tick;
    logic              bcast;
    logic              addr_match;
    logic              par_ok;

    assign rx         = sync_reg[1];
    assign bit_tick   = (cnt_reg == BIT_LAST);
    assign bcast      = is_broadcast(64'(addr_reg), ADDR_W);
    assign addr_match = (addr_reg == address) || bcast;
    assign busy       = (state_reg != ST_IDLE);

`ifdef PERCEPT_BUS_PARITY_EN
    logic par_bit_reg;
    assign par_ok = ~^{addr_reg, op_reg, payload_reg, par_bit_reg};
`else
    assign par_ok = 1'b1;
`endif

    // Two-flop synchroniser for the request line, idle/reset value high.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) sync_reg <= 2'b11;
        else       sync_reg <= {sync_reg[0], serial_in};
    end

    // Receive / execute FSM with registered core controls.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            addr_reg    <= '0;
            op_reg      <= OP_NOP;
            payload_reg <= '0;
            rd_buf_reg  <= '0;
            tx_load_reg <= 1'b0;
            shift_in    <= 1'b0;
            shift_out   <= 1'b0;
            mul_and_acc <= 1'b0;
            data_in     <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PERCEPT_BUS_PARITY_EN
            par_bit_reg <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            tx_load_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    if (!rx) state_reg <= ST_START;
                end
                ST_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= rx ? ST_IDLE : ST_ADDR;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (bit_tick) begin
                        cnt_reg  <= '0;
                        addr_reg <= {addr_reg[ADDR_W-2:0], rx};
                        if (idx_reg == ADDR_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= ST_OP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_OP: begin
                    if (bit_tick) begin
                        cnt_reg <= '0;
                        op_reg  <= {op_reg[0], rx};
                        if (idx_reg == OP_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= ST_DATA;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt_reg <= '0;
`ifdef PERCEPT_BUS_PARITY_EN
                        if (idx_reg == XFER_END) par_bit_reg <= rx;
                        else payload_reg <= {rx, payload_reg[DATA_W-1:1]};
`else
                        payload_reg <= {rx, payload_reg[DATA_W-1:1]};
`endif
                        if (idx_reg == DATA_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= ST_STOP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= ST_IDLE;
                        if (!rx || !par_ok) begin
                            frame_err <= 1'b1;
                        end else if (addr_match) begin
                            // First EXEC cycle is set up here so it follows the stop sample directly.
                            case (op_reg)
                                OP_WRITE: begin
                                    state_reg   <= ST_EXEC;
                                    shift_in    <= 1'b1;
                                    data_in     <= payload_reg[0];
                                    payload_reg <= {1'b0, payload_reg[DATA_W-1:1]};
                                    idx_reg     <= IDX_W'(1);
                                end
                                OP_MAC: begin
                                    state_reg   <= ST_EXEC;
                                    mul_and_acc <= 1'b1;
                                end
                                OP_READ: begin
                                    if (!bcast) begin
                                        state_reg <= ST_EXEC;
                                        shift_out <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (op_reg)
                        OP_WRITE: begin
                            if (idx_reg == XFER_END) begin
                                shift_in  <= 1'b0;
                                data_in   <= 1'b0;
                                state_reg <= ST_IDLE;
                            end else begin
                                data_in     <= payload_reg[0];
                                payload_reg <= {1'b0, payload_reg[DATA_W-1:1]};
                                idx_reg     <= idx_reg + 1'b1;
                            end
                        end
                        OP_MAC: begin
                            mul_and_acc <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end
                        OP_READ: begin
                            // Shift captured bits in from the top so the first capture ends at bit 0.
                            rd_buf_reg <= {data_out, rd_buf_reg[DATA_W-1:1]};
                            if (idx_reg == XFER_LAST) begin
                                shift_out   <= 1'b0;
                                tx_load_reg <= 1'b1;
                                idx_reg     <= '0;
                                state_reg   <= ST_REPLY;
                            end else begin
                                idx_reg <= idx_reg + 1'b1;
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
                ST_REPLY: begin
                    if (tx_done) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    percept_bus_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .nRst       (nRst),
        .load       (tx_load_reg),
        .data       (rd_buf_reg),
        .serial_out (serial_out),
        .done       (tx_done)
    );

endmodule
